// File: rtl/lru_sched_if.sv
// Client-side and LRU-array-side signals of the LRU port scheduler.
// master = cache lookup/miss logic plus LRU array, slave = lru_sched.
interface lru_sched_if #(
  parameter int INDEX_BITS  = 8,
  parameter int OUTPUT_BITS = 2
);
  logic                   hit_valid;
  logic                   hit_ready;
  logic [INDEX_BITS-1:0]  hit_index;
  logic [OUTPUT_BITS-1:0] hit_way;
  logic                   vic_req_valid;
  logic                   vic_req_ready;
  logic [INDEX_BITS-1:0]  vic_req_index;
  logic                   vic_valid;
  logic [OUTPUT_BITS-1:0] vic_way;
  logic                   fill_valid;
  logic [INDEX_BITS-1:0]  fill_index;
  logic [OUTPUT_BITS-1:0] fill_way;
  logic                   miss_busy;
  logic [INDEX_BITS-1:0]  lru_line_selector;
  logic                   lru_update;
  logic [OUTPUT_BITS-1:0] lru_referenced_set;
  logic [OUTPUT_BITS-1:0] lru_way;

  modport master (
    output hit_valid, hit_index, hit_way,
    output vic_req_valid, vic_req_index,
    output fill_valid, fill_index, fill_way,
    output lru_way,
    input  hit_ready, vic_req_ready,
    input  vic_valid, vic_way, miss_busy,
    input  lru_line_selector, lru_update,
    input  lru_referenced_set
  );

  modport slave (
    input  hit_valid, hit_index, hit_way,
    input  vic_req_valid, vic_req_index,
    input  fill_valid, fill_index, fill_way,
    input  lru_way,
    output hit_ready, vic_req_ready,
    output vic_valid, vic_way, miss_busy,
    output lru_line_selector, lru_update,
    output lru_referenced_set
  );
endinterface

// File: rtl/lru_sched.sv
// Single-port LRU array scheduler: refills, hit-update FIFO and victim reads.
// Define LRU_SCHED_BYPASS_EN for same-cycle hit updates when the FIFO is empty.
module lru_sched #(
  parameter int ASSOCIATIVITY = 4,
  parameter int ENTRIES       = 256,
  parameter int INDEX_BITS    = 8,
  parameter int OUTPUT_BITS   = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input logic        clk,
  input logic        rst,
  lru_sched_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  if (OUTPUT_BITS != $clog2(ASSOCIATIVITY) ||
      !(ASSOCIATIVITY == 4 || ASSOCIATIVITY == 8 ||
        ASSOCIATIVITY == 16) ||
      ENTRIES > 2**INDEX_BITS || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("lru_sched: inconsistent parameters");
  end

  typedef enum logic {IDLE, WAIT_FILL} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_BITS-1:0]  idx_q [FIFO_DEPTH];
  logic [INDEX_BITS-1:0]  idx_d [FIFO_DEPTH];
  logic [OUTPUT_BITS-1:0] way_q [FIFO_DEPTH];
  logic [OUTPUT_BITS-1:0] way_d [FIFO_DEPTH];
  logic [PW-1:0]          rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   hit_ready_q, hit_ready_d;
  logic                   vic_valid_q, vic_valid_d;
  logic [OUTPUT_BITS-1:0] vic_way_q, vic_way_d;
  logic                   miss_busy_q, miss_busy_d;

  logic                   full, empty, hazard;
  logic [PW-1:0]          off;
  logic                   grant, deq, enq, byp, upd;
  logic [INDEX_BITS-1:0]  sel;
  logic [OUTPUT_BITS-1:0] set;

  // Only slots between head and head+count are live for the CAM
  always_comb begin
    full   = cnt_q == CW'(FIFO_DEPTH);
    empty  = cnt_q == '0;
    hazard = 1'b0;
    off    = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PW'(i) - rd_q;
      if (CW'(off) < cnt_q &&
          idx_q[i] == bus.vic_req_index) begin
        hazard = 1'b1;
      end
    end
  end

  always_comb begin
    sel   = '0;
    set   = '0;
    upd   = 1'b0;
    grant = 1'b0;
    deq   = 1'b0;
    byp   = 1'b0;
    if (!rst) begin
      if (bus.fill_valid) begin
        upd = 1'b1;
        sel = bus.fill_index;
        set = bus.fill_way;
      end else if (full) begin
        deq = 1'b1;
      end else if (state_q == IDLE &&
                   bus.vic_req_valid && !hazard) begin
        grant = 1'b1;
        sel   = bus.vic_req_index;
      end else if (!empty) begin
        deq = 1'b1;
`ifdef LRU_SCHED_BYPASS_EN
      end else if (bus.hit_valid) begin
        byp = 1'b1;
        upd = 1'b1;
        sel = bus.hit_index;
        set = bus.hit_way;
`endif
      end
    end
    if (deq) begin
      upd = 1'b1;
      sel = idx_q[rd_q];
      set = way_q[rd_q];
    end
  end

  always_comb begin
    enq   = bus.hit_valid && hit_ready_q && !byp && !rst;
    idx_d = idx_q;
    way_d = way_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (enq) begin
      idx_d[wr_q] = bus.hit_index;
      way_d[wr_q] = bus.hit_way;
      wr_d        = wr_q + PW'(1);
    end
    if (deq) rd_d = rd_q + PW'(1);
    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    hit_ready_d = cnt_d != CW'(FIFO_DEPTH);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (grant) state_d = WAIT_FILL;
      WAIT_FILL: if (bus.fill_valid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    miss_busy_d = state_d == WAIT_FILL;
    vic_valid_d = grant;
    vic_way_d   = grant ? bus.lru_way : vic_way_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      hit_ready_q <= 1'b1;
      vic_valid_q <= 1'b0;
      vic_way_q   <= '0;
      miss_busy_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        idx_q[i] <= '0;
        way_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      hit_ready_q <= hit_ready_d;
      vic_valid_q <= vic_valid_d;
      vic_way_q   <= vic_way_d;
      miss_busy_q <= miss_busy_d;
      idx_q       <= idx_d;
      way_q       <= way_d;
    end
  end

  assign bus.hit_ready          = hit_ready_q;
  assign bus.vic_req_ready      = grant;
  assign bus.vic_valid          = vic_valid_q;
  assign bus.vic_way            = vic_way_q;
  assign bus.miss_busy          = miss_busy_q;
  assign bus.lru_line_selector  = sel;
  assign bus.lru_update         = upd;
  assign bus.lru_referenced_set = set;
endmodule

// File: tb/tb_lru_sched.sv
// Bench for lru_sched: directed scenarios with literal checks, then
// random traffic compared every cycle against a queue-based model.
module tb_lru_sched;
`ifdef LRU_SCHED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] idx;
    logic [1:0] way;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lru_sched_if #(.INDEX_BITS(8), .OUTPUT_BITS(2)) bus ();

  lru_sched #(
    .ASSOCIATIVITY(4), .ENTRIES(256), .INDEX_BITS(8),
    .OUTPUT_BITS(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [1:0] way_of(input logic [7:0] i);
    return i[1:0] ^ i[3:2] ^ i[5:4] ^ i[7:6];
  endfunction

  // Stand-in LRU array: way is a fixed function of the selected line
  always_comb bus.lru_way = way_of(bus.lru_line_selector);

  ent_t       q[$];
  bit         m_busy = 1'b0;
  bit         m_vv   = 1'b0;
  logic [1:0] m_vw   = '0;
  int         n_vec  = 0;
  int         n_bad  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit hv,
                      input logic [7:0] hi, input logic [1:0] hw,
                      input bit vv, input logic [7:0] vi,
                      input bit fv, input logic [7:0] fi,
                      input logic [1:0] fw);
    bit e_rdy, e_upd, e_gnt, pop, bypass, haz;
    logic [7:0] e_sel;
    logic [1:0] e_set;
    @(negedge clk);
    rst               = r;
    bus.hit_valid     = hv;
    bus.hit_index     = hi;
    bus.hit_way       = hw;
    bus.vic_req_valid = vv;
    bus.vic_req_index = vi;
    bus.fill_valid    = fv;
    bus.fill_index    = fi;
    bus.fill_way      = fw;
    #1;
    e_rdy = q.size() < 4;
    e_upd = 0; e_gnt = 0; pop = 0; bypass = 0; haz = 0;
    e_sel = '0; e_set = '0;
    foreach (q[i]) if (q[i].idx == vi) haz = 1;
    if (!r) begin
      if (fv) begin
        e_upd = 1; e_sel = fi; e_set = fw;
      end else if (q.size() == 4) begin
        pop = 1;
      end else if (!m_busy && vv && !haz) begin
        e_gnt = 1; e_sel = vi;
      end else if (q.size() > 0) begin
        pop = 1;
      end else if (BYP && hv) begin
        bypass = 1; e_upd = 1; e_sel = hi; e_set = hw;
      end
    end
    if (pop) begin
      e_upd = 1; e_sel = q[0].idx; e_set = q[0].way;
    end
    chk("hit_ready", bus.hit_ready, e_rdy);
    chk("vic_req_ready", bus.vic_req_ready, e_gnt);
    chk("vic_valid", bus.vic_valid, m_vv);
    chk("vic_way", bus.vic_way, m_vw);
    chk("miss_busy", bus.miss_busy, m_busy);
    chk("lru_update", bus.lru_update, e_upd);
    chk("lru_line_selector", bus.lru_line_selector, e_sel);
    if (!e_gnt) chk("lru_referenced_set", bus.lru_referenced_set, e_set);
    if (r) begin
      q.delete();
      m_busy = 0; m_vv = 0; m_vw = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (hv && e_rdy && !bypass) q.push_back(ent_t'{idx: hi, way: hw});
      m_vv = e_gnt;
      if (e_gnt) m_vw = way_of(vi);
      if (e_gnt) m_busy = 1;
      else if (fv) m_busy = 0;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.hit_valid = 0; bus.hit_index = 0; bus.hit_way = 0;
    bus.vic_req_valid = 0; bus.vic_req_index = 0;
    bus.fill_valid = 0; bus.fill_index = 0; bus.fill_way = 0;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("rst hit_ready", bus.hit_ready, 1);
    chk("rst vic_valid", bus.vic_valid, 0);
    chk("rst miss_busy", bus.miss_busy, 0);
    chk("rst lru_update", bus.lru_update, 0);

    // single hit 5/2
    step(0, 1, 5, 2, 0, 0, 0, 0, 0);
    if (BYP) chk("byp hit sel", bus.lru_line_selector, 5);
    chk("hit0 upd", bus.lru_update, BYP);
    idle();
    if (!BYP) begin
      chk("hit1 sel", bus.lru_line_selector, 5);
      chk("hit1 set", bus.lru_referenced_set, 2);
    end
    chk("hit1 upd", bus.lru_update, !BYP);

    // victim hazard on index 9
    step(0, 1, 9, 1, 0, 0, 1, 40, 0);
    step(0, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("haz stall", bus.vic_req_ready, 0);
    chk("haz drain sel", bus.lru_line_selector, 9);
    step(0, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("haz grant", bus.vic_req_ready, 1);
    chk("haz read upd", bus.lru_update, 0);
    idle();
    chk("haz vic_valid", bus.vic_valid, 1);
    chk("haz vic_way", bus.vic_way, 3);
    chk("haz busy", bus.miss_busy, 1);

    // second miss stalls until the fill
    step(0, 1, 11, 3, 1, 30, 0, 0, 0);
    chk("2nd stall", bus.vic_req_ready, 0);
    step(0, 0, 0, 0, 1, 30, 1, 31, 2);
    chk("2nd fill sel", bus.lru_line_selector, 31);
    step(0, 0, 0, 0, 1, 30, 0, 0, 0);
    chk("2nd grant", bus.vic_req_ready, 1);
    idle();

    // fill collides with victim request and non-empty FIFO
    step(0, 1, 7, 0, 0, 0, 1, 50, 1);
    step(0, 0, 0, 0, 1, 12, 1, 3, 1);
    chk("col sel", bus.lru_line_selector, 3);
    chk("col set", bus.lru_referenced_set, 1);
    chk("col stall", bus.vic_req_ready, 0);
    step(0, 0, 0, 0, 1, 12, 0, 0, 0);
    chk("col grant", bus.vic_req_ready, 1);
    idle();

    // reset while a miss is outstanding
    chk("pre-rst busy", bus.miss_busy, 1);
    step(1, 1, 21, 1, 0, 0, 0, 0, 0);
    idle();
    chk("post-rst hit_ready", bus.hit_ready, 1);
    chk("post-rst busy", bus.miss_busy, 0);
    chk("post-rst upd", bus.lru_update, 0);
    chk("post-rst vic_valid", bus.vic_valid, 0);

    // random traffic: light fills, then heavy fills to fill the FIFO
    for (int k = 0; k < 6000; k++) begin
      bit fv;
      bit r;
      r  = (k < 3000) && ($urandom_range(99) == 0);
      fv = (k < 3000) ? ($urandom_range(9) == 0)
                      : ($urandom_range(1) == 0);
      step(r, $urandom_range(9) < 7,
           8'($urandom_range(15)), 2'($urandom_range(3)),
           $urandom_range(9) < 4, 8'($urandom_range(15)),
           fv, 8'($urandom_range(255)), 2'($urandom_range(3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
